// File: rtl/regfile_wb.sv
// regfile_wb
// Register file at the consumer end of the write-back interface.
//   - 32 GPRs (r0 hard-wired to zero) plus a HI/LO pair, written on the
//     rising edge of clk by the write-back stage.
//   - Two combinational read ports for decode, with same-cycle bypass of
//     the write-back data.
//   - Per-register 2-bit pending-write counters so decode can detect RAW
//     hazards on producers that have issued but not yet written back.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   we, waddr, wdata         GPR write-back
//   hilo_we, hi_i, lo_i      HI/LO write-back
//   re1/raddr1 -> rdata1     read port 1 (combinational)
//   re2/raddr2 -> rdata2     read port 2 (combinational)
//   hi_o, lo_o               current HI/LO, bypassed
//   issue_valid, issue_addr  decode issued a writer of issue_addr
//   busy1, busy2             read address has an outstanding writer
module regfile_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        hilo_we,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic        busy1,
    output logic        busy2
);

    logic [31:0] r_regs [0:31];
    logic [1:0]  r_cnt  [0:31];
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_gpr_wr;
    logic        w_issue;

    assign w_gpr_wr = we && (waddr != 5'd0);
    assign w_issue  = issue_valid && (issue_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
                r_cnt[i]  <= 2'd0;
            end
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_gpr_wr) begin
                r_regs[waddr] <= wdata;
            end
            if (hilo_we) begin
                r_hi <= hi_i;
                r_lo <= lo_i;
            end
            // r0 never gets a counter update, so it stays at zero forever.
            // An issue and a write-back to the same register cancel out.
            for (int i = 1; i < 32; i++) begin
                if (w_issue && (issue_addr == 5'(i)) &&
                    !(w_gpr_wr && (waddr == 5'(i)))) begin
                    if (r_cnt[i] != 2'd3) begin
                        r_cnt[i] <= r_cnt[i] + 2'd1;
                    end
                end else if (w_gpr_wr && (waddr == 5'(i)) &&
                             !(w_issue && (issue_addr == 5'(i)))) begin
                    if (r_cnt[i] != 2'd0) begin
                        r_cnt[i] <= r_cnt[i] - 2'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        rdata1 = 32'd0;
        if (!rst && re1 && (raddr1 != 5'd0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = r_regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = 32'd0;
        if (!rst && re2 && (raddr2 != 5'd0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = r_regs[raddr2];
            end
        end
    end

    always_comb begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        if (!rst) begin
            hi_o = hilo_we ? hi_i : r_hi;
            lo_o = hilo_we ? lo_i : r_lo;
        end
    end

    // The last outstanding writer is being bypassed this cycle, so it does
    // not need to stall the reader.
    always_comb begin
        busy1 = 1'b0;
        if (!rst && re1 && (raddr1 != 5'd0) && (r_cnt[raddr1] != 2'd0)) begin
            busy1 = !(we && (waddr == raddr1) && (r_cnt[raddr1] == 2'd1));
        end
    end

    always_comb begin
        busy2 = 1'b0;
        if (!rst && re2 && (raddr2 != 5'd0) && (r_cnt[raddr2] != 2'd0)) begin
            busy2 = !(we && (waddr == raddr2) && (r_cnt[raddr2] == 2'd1));
        end
    end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Register file at the consumer end of the write-back interface. Accepts the write-back stage's destination address, write enable and data, and commits them to 32 general-purpose registers plus the HI/LO pair. Serves two combinational read ports to decode with same-cycle write-back bypass. Keeps a per-register pending-write scoreboard so decode can detect RAW hazards on producers still in flight.

## Interface
- Parameters: none; data width is 32 bits, register address width is 5 bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- we  in  1  write-back write enable.
- waddr  in  5  write-back destination register.
- wdata  in  32  write-back data.
- hilo_we  in  1  HI/LO write enable.
- hi_i  in  32  HI write data.
- lo_i  in  32  LO write data.
- re1  in  1  read port 1 enable.
- raddr1  in  5  read port 1 address.
- rdata1  out  32  read port 1 data (combinational).
- re2  in  1  read port 2 enable.
- raddr2  in  5  read port 2 address.
- rdata2  out  32  read port 2 data (combinational).
- hi_o  out  32  current HI, bypassed.
- lo_o  out  32  current LO, bypassed.
- issue_valid  in  1  decode issued an instruction that will write issue_addr.
- issue_addr  in  5  destination of the issued instruction.
- busy1  out  1  raddr1 has an outstanding writer.
- busy2  out  1  raddr2 has an outstanding writer.

## Operation
- GPR write: on posedge, when we=1, waddr!=0 and rst=0, regs[waddr] <= wdata. Writes to r0 are discarded; r0 always reads 0.
- HI/LO write: on posedge, when hilo_we=1 and rst=0, HI <= hi_i and LO <= lo_i together.
- Read port n, priority order:
  - rst=1 -> 0.
  - re=0 -> 0.
  - raddr=0 -> 0.
  - we=1 and waddr==raddr -> wdata (bypass).
  - otherwise regs[raddr].
  - Ports are independent; both may hit the same register or the bypass in the same cycle.
- hi_o/lo_o: hi_i/lo_i while hilo_we=1, else stored HI/LO; 0 while rst=1.
- Scoreboard: one 2-bit counter per register r1..r31; r0 has none and is never busy.
  - issue_valid=1 and issue_addr!=0 -> increment cnt[issue_addr].
  - we=1 and waddr!=0 -> decrement cnt[waddr].
  - Both on the same register in one cycle -> no change.
  - Increment saturates at 3; decrement at 0 does not underflow.
  - Issue and write-back on different registers both take effect.
- busyn = (cnt[raddrn] != 0) and raddrn != 0 and not (we=1, waddr==raddrn, cnt==1). The final write-back is bypassed, so it does not stall. busyn is 0 while rst=1 or ren=0.

## Timing
- Reset: on the first posedge with rst=1, all GPRs, HI, LO and all counters clear to 0. While rst=1, rdata1, rdata2, hi_o, lo_o, busy1 and busy2 are all 0. Writes, HI/LO writes and issues presented during rst are dropped.
- Write latency: data stored at the posedge ending the write cycle. Visible combinationally on the read ports in that same cycle (bypass), and from storage afterward.
- Scoreboard latency: issue in cycle N -> busy visible from cycle N+1. Write-back in cycle M -> busy drops in cycle M when it is the last writer (bypass rule), and the counter reads 0 from M+1.
- No handshakes; every input is sampled every cycle.

## Test plan
- Reset: load r5=0x1234 and HI=7, assert rst one cycle, read r5 and HI -> rdata1=0, hi_o=0, busy1=0.
- Write/read/bypass: we=1, waddr=3, wdata=0xDEADBEEF with raddr1=3, re1=1 in the same cycle -> rdata1=0xDEADBEEF in that cycle and on every later read. Write r0=0xFFFFFFFF, read r0 -> 0.
- Disabled port: re2=0, raddr2=3 -> rdata2=0 regardless of stored value.
- HI/LO: hilo_we=1, hi_i=0x11, lo_i=0x22 -> hi_o=0x11, lo_o=0x22 same cycle and after; hilo_we=0 with new hi_i -> hi_o holds 0x11.
- Scoreboard, two writers: issue r7 in cycles 0 and 1 -> busy1 (raddr1=7) =1 from cycle 1. First write-back of r7 -> busy stays 1. Second write-back of r7 -> busy1=0 in that cycle. Issue and write-back of r9 in the same cycle with cnt[r9]=1 -> count stays 1.
- Saturation/underflow: four issues to r4 -> count 3; write-backs to r4 with count 0 -> count remains 0, busy 0.
